// File: rtl/bfloat_pkg.sv
// Shared types and helpers for the pipelined sign-magnitude float comparator.
package bfloat_pkg;

    localparam int unsigned DEF_EXP_W = 8;
    localparam int unsigned DEF_MAN_W = 7;
    localparam int unsigned MAX_W     = 64;

    typedef enum logic [1:0] {
        CMP_EQ = 2'b00,
        CMP_GT = 2'b01,
        CMP_LT = 2'b10,
        CMP_UN = 2'b11
    } cmp_res_t;

    // Canonical quiet NaN: positive, exponent all ones, mantissa MSB set, rest zero.
    function automatic logic [MAX_W-1:0] canon_qnan(input int unsigned exp_w, input int unsigned man_w);
        logic [MAX_W-1:0] r;
        r = ((MAX_W'(1) << exp_w) - MAX_W'(1)) << man_w;
        r = r | (MAX_W'(1) << (man_w - 1));
        return r;
    endfunction

endpackage

// File: rtl/bfloat_cmp_classify.sv
// Combinational operand classifier: NaN/sNaN/zero flags and a monotonic
// unsigned ordering key (zeros of either sign share the key of +0).
module bfloat_cmp_classify
    import bfloat_pkg::*;
#(
    parameter int unsigned EXP_W = DEF_EXP_W,
    parameter int unsigned MAN_W = DEF_MAN_W,
    parameter bit          FTZ   = 1'b0,
    localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] x,
    output logic         is_nan,
    output logic         is_snan,
    output logic         is_zero,
    output logic [W-1:0] key
);

    logic                   sign;
    logic [EXP_W-1:0]       exp_f;
    logic [MAN_W-1:0]       man;
    logic [EXP_W+MAN_W-1:0] mag;

    // Decode fields, flag special values and build the ordering key.
    always_comb begin
        sign    = x[W-1];
        exp_f   = x[W-2 -: EXP_W];
        man     = x[MAN_W-1:0];
        mag     = x[W-2:0];
        is_nan  = (exp_f == '1) && (man != '0);
        is_snan = is_nan && !man[MAN_W-1];
        is_zero = (exp_f == '0) && ((man == '0) || FTZ);
        if (is_zero) begin
            key = {1'b1, {(W-1){1'b0}}};
        end else if (sign) begin
            key = {1'b0, ~mag};
        end else begin
            key = {1'b1, mag};
        end
    end

endmodule

// File: rtl/bfloat_cmp_pipe.sv
// Two-stage pipelined float comparator with min/max select and valid/ready
// backpressure. Stage 1 registers classified operands, stage 2 registers results.
module bfloat_cmp_pipe
    import bfloat_pkg::*;
#(
    parameter int unsigned EXP_W = DEF_EXP_W,
    parameter int unsigned MAN_W = DEF_MAN_W,
    parameter bit          FTZ   = 1'b0,
    localparam int unsigned W    = 1 + EXP_W + MAN_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic         in_max,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [1:0]   out_res,
    output logic [W-1:0] out_mm,
    output logic         out_inv
);

    localparam logic [W-1:0] QNAN = W'(canon_qnan(EXP_W, MAN_W));

    typedef struct packed {
        logic [W-1:0] val;
        logic         is_nan;
        logic         is_snan;
        logic         is_zero;
        logic [W-1:0] key;
    } opnd_t;

    opnd_t    cl_a, cl_b;
    opnd_t    s1_a, s1_b;
    logic     s1_max;
    logic     s1_valid, s2_valid;
    logic     s1_adv, s2_adv;
    cmp_res_t res;
    logic [W-1:0] mm, ret_a, ret_b;
    logic     inv, zsign;

    bfloat_cmp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FTZ(FTZ)) u_cls_a (
        .x(in_a), .is_nan(cl_a.is_nan), .is_snan(cl_a.is_snan),
        .is_zero(cl_a.is_zero), .key(cl_a.key)
    );
    bfloat_cmp_classify #(.EXP_W(EXP_W), .MAN_W(MAN_W), .FTZ(FTZ)) u_cls_b (
        .x(in_b), .is_nan(cl_b.is_nan), .is_snan(cl_b.is_snan),
        .is_zero(cl_b.is_zero), .key(cl_b.key)
    );
    assign cl_a.val = in_a;
    assign cl_b.val = in_b;

    assign s2_adv    = !s2_valid || out_ready;
    assign s1_adv    = !s1_valid || s2_adv;
    assign in_ready  = s1_adv;
    assign out_valid = s2_valid;

    // Stage 1: capture classified operands when the stage can move.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_a     <= '0;
            s1_b     <= '0;
            s1_max   <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_a   <= cl_a;
                s1_b   <= cl_b;
                s1_max <= in_max;
            end
        end
    end

    // Stage 2 compare: flushed subnormals come back as signed zero.
    always_comb begin
        ret_a = s1_a.is_zero ? {s1_a.val[W-1], {(W-1){1'b0}}} : s1_a.val;
        ret_b = s1_b.is_zero ? {s1_b.val[W-1], {(W-1){1'b0}}} : s1_b.val;
        zsign = s1_max ? (s1_a.val[W-1] & s1_b.val[W-1]) : (s1_a.val[W-1] | s1_b.val[W-1]);
        res   = CMP_EQ;
        mm    = ret_a;
        inv   = s1_a.is_snan | s1_b.is_snan;
        if (s1_a.is_nan || s1_b.is_nan) begin
            res = CMP_UN;
            if (s1_a.is_nan && s1_b.is_nan) mm = QNAN;
            else if (s1_a.is_nan)           mm = ret_b;
            else                            mm = ret_a;
        end else if (s1_a.key > s1_b.key) begin
            res = CMP_GT;
            mm  = s1_max ? ret_a : ret_b;
        end else if (s1_a.key < s1_b.key) begin
            res = CMP_LT;
            mm  = s1_max ? ret_b : ret_a;
        end else if (s1_a.is_zero && s1_b.is_zero) begin
            mm = {zsign, {(W-1){1'b0}}};
        end
    end

    // Stage 2 register: results held while the consumer stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid <= 1'b0;
            out_res  <= '0;
            out_mm   <= '0;
            out_inv  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                out_res <= res;
                out_mm  <= mm;
                out_inv <= inv;
            end
        end
    end

endmodule

// File: tb/tb_bfloat_cmp_pipe.sv
// Self-checking bench: bf16 (FTZ=0), bf16 (FTZ=1) and fp16 instances share
// stimulus; expectations come from a real-valued reference model and a table.
module tb_bfloat_cmp_pipe;

    typedef struct {
        logic [1:0]  res;
        logic [15:0] mm;
        logic        inv;
    } exp_t;

    typedef struct {
        string       name;
        int          sel;
        logic [15:0] a;
        logic [15:0] b;
        logic        mx;
        logic [1:0]  res;
        logic [15:0] mm;
        logic        inv;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_max = 1'b0;
    logic        out_ready = 1'b1;
    logic [15:0] in_a = '0;
    logic [15:0] in_b = '0;
    logic [2:0]  in_ready_v, out_valid_v, inv_v;
    logic [1:0]  res_v [3];
    logic [15:0] mm_v  [3];

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q0[$], q1[$], q2[$];
    bit   stalled = 0;
    exp_t hold;

    always #5 clk = ~clk;

    bfloat_cmp_pipe #(.EXP_W(8), .MAN_W(7), .FTZ(1'b0)) u_bf16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[0]),
        .in_a(in_a), .in_b(in_b), .in_max(in_max), .out_valid(out_valid_v[0]),
        .out_ready(out_ready), .out_res(res_v[0]), .out_mm(mm_v[0]), .out_inv(inv_v[0]));
    bfloat_cmp_pipe #(.EXP_W(8), .MAN_W(7), .FTZ(1'b1)) u_ftz (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[1]),
        .in_a(in_a), .in_b(in_b), .in_max(in_max), .out_valid(out_valid_v[1]),
        .out_ready(out_ready), .out_res(res_v[1]), .out_mm(mm_v[1]), .out_inv(inv_v[1]));
    bfloat_cmp_pipe #(.EXP_W(5), .MAN_W(10), .FTZ(1'b0)) u_fp16 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_v[2]),
        .in_a(in_a), .in_b(in_b), .in_max(in_max), .out_valid(out_valid_v[2]),
        .out_ready(out_ready), .out_res(res_v[2]), .out_mm(mm_v[2]), .out_inv(inv_v[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Format parameters per instance index.
    function automatic int ew_of(input int d); return (d == 2) ? 5 : 8; endfunction
    function automatic int mw_of(input int d); return (d == 2) ? 10 : 7; endfunction
    function automatic bit ftz_of(input int d); return d == 1; endfunction

    // Numeric value of an operand; infinity represented by a huge sentinel.
    function automatic real fval(input logic [15:0] x, input int ew, input int mw, input bit ftz);
        int e, m, bias;
        real v;
        e    = int'(x[14:0]) >> mw;
        m    = int'(x) & ((1 << mw) - 1);
        bias = (1 << (ew - 1)) - 1;
        if (e == (1 << ew) - 1) v = 1.0e300;
        else if (e == 0)        v = ftz ? 0.0 : real'(m) * (2.0 ** (1 - bias - mw));
        else                    v = (real'(m) + 2.0 ** mw) * (2.0 ** (e - bias - mw));
        return x[15] ? -v : v;
    endfunction

    function automatic bit is_nan_m(input logic [15:0] x, input int ew, input int mw);
        int e, m;
        e = int'(x[14:0]) >> mw;
        m = int'(x) & ((1 << mw) - 1);
        return (e == (1 << ew) - 1) && (m != 0);
    endfunction

    function automatic bit is_snan_m(input logic [15:0] x, input int ew, input int mw);
        int m;
        m = int'(x) & ((1 << mw) - 1);
        return is_nan_m(x, ew, mw) && (((m >> (mw - 1)) & 1) == 0);
    endfunction

    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic mx, input int d);
        exp_t r;
        int ew, mw;
        bit ftz, na, nb;
        real va, vb;
        logic [15:0] ra, rb;
        ew = ew_of(d); mw = mw_of(d); ftz = ftz_of(d);
        na = is_nan_m(a, ew, mw);
        nb = is_nan_m(b, ew, mw);
        va = fval(a, ew, mw, ftz);
        vb = fval(b, ew, mw, ftz);
        ra = (va == 0.0) ? {a[15], 15'h0} : a;
        rb = (vb == 0.0) ? {b[15], 15'h0} : b;
        r.inv = is_snan_m(a, ew, mw) | is_snan_m(b, ew, mw);
        if (na || nb) begin
            r.res = 2'b11;
            if (na && nb) r.mm = 16'((((1 << ew) - 1) << mw) | (1 << (mw - 1)));
            else          r.mm = na ? rb : ra;
        end else if (va > vb) begin
            r.res = 2'b01; r.mm = mx ? ra : rb;
        end else if (va < vb) begin
            r.res = 2'b10; r.mm = mx ? rb : ra;
        end else begin
            r.res = 2'b00;
            if (va == 0.0) r.mm = {mx ? (a[15] & b[15]) : (a[15] | b[15]), 15'h0};
            else           r.mm = a;
        end
        return r;
    endfunction

    task automatic pop_check(input int d);
        exp_t e;
        int sz;
        sz = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
        if (sz == 0) begin
            chk($sformatf("spurious_valid%0d", d), out_valid_v[d], 0);
            return;
        end
        if (d == 0) e = q0.pop_front();
        else if (d == 1) e = q1.pop_front();
        else e = q2.pop_front();
        chk($sformatf("res%0d", d), res_v[d], e.res);
        chk($sformatf("mm%0d", d), mm_v[d], e.mm);
        chk($sformatf("inv%0d", d), inv_v[d], e.inv);
    endtask

    // One cycle: drive on the falling edge, then score the transfers that the
    // next rising edge will perform.
    task automatic step(input logic [15:0] a, input logic [15:0] b, input logic mx,
                        input logic iv, input logic ordy, output bit took);
        @(negedge clk);
        if (stalled) begin
            chk("stall_valid", out_valid_v[0], 1);
            chk("stall_res", res_v[0], hold.res);
            chk("stall_mm", mm_v[0], hold.mm);
            chk("stall_inv", inv_v[0], hold.inv);
        end
        in_a = a; in_b = b; in_max = mx; in_valid = iv; out_ready = ordy;
        #1;
        chk("in_ready", in_ready_v[0], !(q0.size() == 2 && !ordy));
        took = iv && in_ready_v[0];
        for (int d = 0; d < 3; d++)
            if (out_valid_v[d] && ordy) pop_check(d);
        stalled = out_valid_v[0] && !ordy;
        if (stalled) begin
            hold.res = res_v[0]; hold.mm = mm_v[0]; hold.inv = inv_v[0];
        end
        if (took) begin
            q0.push_back(model(a, b, mx, 0));
            q1.push_back(model(a, b, mx, 1));
            q2.push_back(model(a, b, mx, 2));
        end
    endtask

    task automatic drain();
        bit t;
        for (int i = 0; i < 40 && (q0.size() + q1.size() + q2.size()) != 0; i++)
            step(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, t);
        chk("drain_left", q0.size() + q1.size() + q2.size(), 0);
    endtask

    task automatic directed(input vec_t v);
        bit t;
        step(v.a, v.b, v.mx, 1'b1, 1'b1, t);
        chk({v.name, "_accept"}, t, 1);
        step(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, t);
        chk({v.name, "_early"}, out_valid_v[v.sel], 0);
        step(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, t);
        chk({v.name, "_valid"}, out_valid_v[v.sel], 1);
        chk({v.name, "_res"}, res_v[v.sel], v.res);
        chk({v.name, "_mm"}, mm_v[v.sel], v.mm);
        chk({v.name, "_inv"}, inv_v[v.sel], v.inv);
    endtask

    function automatic logic [15:0] rand_op(input logic [15:0] other);
        logic [15:0] sp [8];
        sp = '{16'h0000, 16'h8000, 16'h7F80, 16'hFF80, 16'h7FC0, 16'h7F81, 16'h3F80, 16'h0001};
        case ($urandom_range(0, 3))
            0: return 16'($urandom);
            1: return sp[$urandom_range(0, 7)];
            2: return {1'($urandom), 8'h00, 7'($urandom)};
            default: return other ^ {1'($urandom), 15'h0};
        endcase
    endfunction

    vec_t tbl [14];
    logic [15:0] seq [8];

    initial begin
        bit t;
        int idx;
        logic [15:0] ra, rb;

        tbl[0]  = '{"gt_pos",   0, 16'h4000, 16'h3F80, 1'b1, 2'b01, 16'h4000, 1'b0};
        tbl[1]  = '{"gt_neg",   0, 16'hBF80, 16'hC000, 1'b0, 2'b01, 16'hC000, 1'b0};
        tbl[2]  = '{"lt_neg",   0, 16'hC000, 16'hBF80, 1'b0, 2'b10, 16'hC000, 1'b0};
        tbl[3]  = '{"zero_min", 0, 16'h0000, 16'h8000, 1'b0, 2'b00, 16'h8000, 1'b0};
        tbl[4]  = '{"zero_max", 0, 16'h0000, 16'h8000, 1'b1, 2'b00, 16'h0000, 1'b0};
        tbl[5]  = '{"zero_swp", 0, 16'h8000, 16'h0000, 1'b1, 2'b00, 16'h0000, 1'b0};
        tbl[6]  = '{"inf",      0, 16'h7F80, 16'h7F7F, 1'b1, 2'b01, 16'h7F80, 1'b0};
        tbl[7]  = '{"qnan",     0, 16'h7FC0, 16'h3F80, 1'b0, 2'b11, 16'h3F80, 1'b0};
        tbl[8]  = '{"snan2",    0, 16'h7F81, 16'h7F81, 1'b0, 2'b11, 16'h7FC0, 1'b1};
        tbl[9]  = '{"snan1",    0, 16'h7F81, 16'h3F80, 1'b1, 2'b11, 16'h3F80, 1'b1};
        tbl[10] = '{"sub_noftz",0, 16'h0001, 16'h0000, 1'b1, 2'b01, 16'h0001, 1'b0};
        tbl[11] = '{"sub_ftz",  1, 16'h0001, 16'h0000, 1'b1, 2'b00, 16'h0000, 1'b0};
        tbl[12] = '{"fp16_lt",  2, 16'h3C00, 16'h4000, 1'b0, 2'b10, 16'h3C00, 1'b0};
        tbl[13] = '{"eq_nz",    0, 16'h3F80, 16'h3F80, 1'b1, 2'b00, 16'h3F80, 1'b0};

        // Reset state.
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            chk($sformatf("rst_valid%0d", d), out_valid_v[d], 0);
            chk($sformatf("rst_ready%0d", d), in_ready_v[d], 1);
            chk($sformatf("rst_res%0d", d), res_v[d], 0);
            chk($sformatf("rst_mm%0d", d), mm_v[d], 0);
            chk($sformatf("rst_inv%0d", d), inv_v[d], 0);
        end
        rst = 1'b0;

        foreach (tbl[i]) directed(tbl[i]);

        // Eight back-to-back items under a 1,0,0,1 out_ready pattern.
        for (int i = 0; i < 8; i++) seq[i] = 16'h3F80 + 16'(i * 37);
        idx = 0;
        for (int cyc = 0; cyc < 100 && (idx < 8 || q0.size() != 0); cyc++) begin
            step(idx < 8 ? seq[idx] : 16'h0, 16'h4000, 1'(idx & 1), idx < 8,
                 (cyc % 4 == 0) || (cyc % 4 == 3), t);
            if (t) idx++;
        end
        chk("b2b_accepted", idx, 8);
        drain();

        // Reset with two items in flight.
        step(16'h4000, 16'h3F80, 1'b0, 1'b1, 1'b0, t);
        step(16'h3F80, 16'h4000, 1'b0, 1'b1, 1'b0, t);
        @(negedge clk);
        chk("pre_rst_valid", out_valid_v[0], 1);
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", out_valid_v[0], 0);
        chk("mid_rst_ready", in_ready_v[0], 1);
        q0.delete(); q1.delete(); q2.delete();
        stalled = 0;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(16'h0, 16'h0, 1'b0, 1'b0, 1'b1, t);
            chk("post_rst_idle", out_valid_v[0], 0);
        end

        // Randomised traffic against the reference model.
        for (int i = 0; i < 400; i++) begin
            ra = rand_op(16'($urandom));
            rb = rand_op(ra);
            step(ra, rb, 1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7, t);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
